// File: rtl/uart_rx_core_if.sv
// ============================================================================
//  Module      : uart_rx_core_if
//  Description : Host-side bus of the UART receiver. The host pulses read_ack
//                after it has consumed data_out. The receiver returns the
//                character and its status flags.
//  Signals     : read_ack    - host -> receiver, one-clk acknowledge pulse
//                data_out    - receiver -> host, last accepted character
//                rx_rdy      - receiver -> host, character waiting
//                overflow    - receiver -> host, a character was dropped
//                parity_err  - receiver -> host, parity mismatch on last frame
//                framing_err - receiver -> host, stop bit sampled low
//  Modports    : master (host side), slave (receiver side)
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_core_if;
  logic       read_ack;
  logic [7:0] data_out;
  logic       rx_rdy;
  logic       overflow;
  logic       parity_err;
  logic       framing_err;

  modport master (
    output read_ack,
    input  data_out, rx_rdy, overflow, parity_err, framing_err
  );

  modport slave (
    input  read_ack,
    output data_out, rx_rdy, overflow, parity_err, framing_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
//  Module      : uart_rx_core
//  Description : UART receiver core. It has a 16x oversampled bit engine with
//                a metastability synchronizer, a 3-sample majority filter,
//                7/8 data bits, optional parity, and a single-entry holding
//                register with overflow detection.
//  Ports       : clk         - system clock, rising edge
//                aresetn     - asynchronous active-low reset
//                baud_clock  - one-clk enable pulse at 16x the baud rate
//                rx          - asynchronous serial input, idle high
//                bit8        - 1: 8 data bits, 0: 7 data bits
//                parity_en   - parity bit present (parity build only)
//                odd_n_even  - 1: odd parity, 0: even (parity build only)
//                host        - uart_rx_core_if.slave (read_ack, data_out,
//                              rx_rdy, overflow, parity_err, framing_err)
//  Parameters  : SYNC_STAGES - rx synchronizer depth, 2 or 3
//  Build macro : UART_RX_PARITY_EN - builds the PARITY state and drives
//                parity_err. When it is undefined, parity_en/odd_n_even are
//                ignored and parity_err reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           aresetn,
  input  logic           baud_clock,
  input  logic           rx,
  input  logic           bit8,
  input  logic           parity_en,
  input  logic           odd_n_even,
  uart_rx_core_if.slave  host
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             filt_q, filt_d;
  logic                   rx_sync;
  logic                   rx_filt;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    filt_d = filt_q;
    if (baud_clock) begin
      filt_d = {filt_q[1:0], rx_sync};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];
  // Two out of three recent samples decide the line level. A single-sample
  // glitch cannot start a frame or corrupt a data bit.
  assign rx_filt = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) |
                   (filt_q[1] & filt_q[2]);

  // --------------------------------------------------------------------------
  // Bit engine
  // --------------------------------------------------------------------------
  logic [2:0] state_q, state_d;
  logic [3:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       cfg_bit8_q, cfg_bit8_d;
  logic       frame_done;
  logic       frame_ferr;
  logic       frame_perr;
  logic [2:0] last_bit;

`ifdef UART_RX_PARITY_EN
  logic       cfg_par_q, cfg_par_d;
  logic       cfg_odd_q, cfg_odd_d;
  logic       perr_frame_q, perr_frame_d;
  assign frame_perr = perr_frame_q;
`else
  logic       unused_par_cfg;
  assign unused_par_cfg = parity_en ^ odd_n_even;
  assign frame_perr     = 1'b0;
`endif

  assign last_bit = cfg_bit8_q ? 3'd7 : 3'd6;

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cfg_bit8_d = cfg_bit8_q;
`ifdef UART_RX_PARITY_EN
    cfg_par_d    = cfg_par_q;
    cfg_odd_d    = cfg_odd_q;
    perr_frame_d = perr_frame_q;
`endif
    frame_done = 1'b0;
    frame_ferr = 1'b0;

    if (baud_clock) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_filt) begin
            state_d    = S_START;
            samp_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            // Bits that are not received must read as 0. This keeps
            // data_out[7] clear in 7-bit mode.
            shift_d    = 8'h00;
            // The frame format is frozen here. Later changes to the format
            // inputs wait for the next start bit.
            cfg_bit8_d = bit8;
`ifdef UART_RX_PARITY_EN
            cfg_par_d    = parity_en;
            cfg_odd_d    = odd_n_even;
            perr_frame_d = 1'b0;
`endif
          end
        end

        S_START: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd7) begin
            // Mid start bit. If the line is high again, the start was a glitch.
            samp_cnt_d = 4'd0;
            state_d    = rx_filt ? S_IDLE : S_DATA;
          end
        end

        S_DATA: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd15) begin
            shift_d[bit_cnt_q] = rx_filt;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == last_bit) begin
`ifdef UART_RX_PARITY_EN
              state_d = cfg_par_q ? S_PARITY : S_STOP;
`else
              state_d = S_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd15) begin
            // Expected bit = XOR of data, inverted for odd parity.
            perr_frame_d = rx_filt ^ (^shift_q) ^ cfg_odd_q;
            state_d      = S_STOP;
          end
        end
`endif

        S_STOP: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd15) begin
            // Return at mid stop bit. The next start edge can then be seen
            // with no idle gap between frames.
            frame_done = 1'b1;
            frame_ferr = ~rx_filt;
            state_d    = S_IDLE;
          end
        end

        default: begin
          state_d    = S_IDLE;
          samp_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Holding register and status
  // --------------------------------------------------------------------------
  logic [7:0] data_out_q, data_out_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic       overflow_q, overflow_d;
  logic       framing_err_q, framing_err_d;
  logic       parity_err_q, parity_err_d;

  always_comb begin
    data_out_d    = data_out_q;
    rx_rdy_d      = rx_rdy_q;
    overflow_d    = overflow_q;
    framing_err_d = framing_err_q;
    parity_err_d  = parity_err_q;

    if (host.read_ack && rx_rdy_q) begin
      rx_rdy_d   = 1'b0;
      overflow_d = 1'b0;
    end

    if (frame_done) begin
      framing_err_d = frame_ferr;
      parity_err_d  = frame_perr;
      if (rx_rdy_q && !host.read_ack) begin
        // The host still owns the old character, so drop the new one.
        overflow_d = 1'b1;
      end else begin
        // An acknowledge in the same clk frees the register for this frame.
        data_out_d = shift_q;
        rx_rdy_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q        <= '1;
      filt_q        <= 3'b111;
      state_q       <= S_IDLE;
      samp_cnt_q    <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      cfg_bit8_q    <= 1'b1;
      data_out_q    <= 8'h00;
      rx_rdy_q      <= 1'b0;
      overflow_q    <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      cfg_par_q     <= 1'b0;
      cfg_odd_q     <= 1'b0;
      perr_frame_q  <= 1'b0;
`endif
    end else begin
      sync_q        <= sync_d;
      filt_q        <= filt_d;
      state_q       <= state_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      cfg_bit8_q    <= cfg_bit8_d;
      data_out_q    <= data_out_d;
      rx_rdy_q      <= rx_rdy_d;
      overflow_q    <= overflow_d;
      framing_err_q <= framing_err_d;
      parity_err_q  <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      cfg_par_q     <= cfg_par_d;
      cfg_odd_q     <= cfg_odd_d;
      perr_frame_q  <= perr_frame_d;
`endif
    end
  end

  assign host.data_out    = data_out_q;
  assign host.rx_rdy      = rx_rdy_q;
  assign host.overflow    = overflow_q;
  assign host.framing_err = framing_err_q;
`ifdef UART_RX_PARITY_EN
  assign host.parity_err  = parity_err_q;
`else
  logic unused_parity_err;
  assign unused_parity_err = parity_err_q;
  assign host.parity_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of rx synchronizer flops, legal values 2..3.
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port baud_clock, input, 1: one-clk pulse at 16x baud rate from the baud generator.
REQ-005 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-006 SHALL have port bit8, input, 1: 1 selects 8 data bits, 0 selects 7.
REQ-007 SHALL have ports parity_en and odd_n_even, input, 1 each: parity enable, and 1=odd / 0=even.
REQ-008 SHALL have port read_ack, input, 1: one-clk pulse from the host after it reads data_out.
REQ-009 SHALL have port data_out, output, 8: last received character.
REQ-010 SHALL have ports rx_rdy, overflow, parity_err and framing_err, output, 1 each.

Function
REQ-011 SHALL synchronize rx through SYNC_STAGES flops reset to 1, then apply a 3-sample majority filter updated only on baud_clock.
REQ-012 SHALL advance all FSM and counter activity only on cycles with baud_clock=1; state SHALL hold otherwise.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY and STOP, with a 4-bit sample counter (wraps 15->0) and a 3-bit bit counter.
REQ-014 IDLE: filtered rx=0 SHALL move the FSM to START and clear the sample counter.
REQ-015 START: at sample count 7, rx=0 SHALL move the FSM to DATA with the counter cleared; rx=1 SHALL return it to IDLE as a false start, with no outputs changed.
REQ-016 DATA: SHALL sample rx at count 15 (mid-bit) and shift it in LSB first.
REQ-017 DATA exit: after 8 bits (bit8=1) or 7 bits (bit8=0), SHALL go to PARITY if parity is enabled, else to STOP.
REQ-018 PARITY: SHALL sample at count 15 and compare against the XOR of the data bits, inverted when odd_n_even=1.
REQ-019 STOP: SHALL sample at count 15 and flag framing_err when rx=0, then return directly to IDLE so that back-to-back frames are accepted.
REQ-020 Completion (stop sample): SHALL load data_out, set rx_rdy, and update framing_err/parity_err in the same clk; data_out[7] SHALL be 0 in 7-bit mode.
REQ-021 framing_err and parity_err SHALL hold their values until the next completion.
REQ-022 read_ack with rx_rdy=1 SHALL clear rx_rdy and overflow on the next clk.
REQ-023 Completion while rx_rdy=1 and read_ack=0: SHALL drop the new character, keep data_out, and set sticky overflow.
REQ-024 Completion coinciding with read_ack: SHALL load the new character, keep rx_rdy=1, and leave overflow=0.
REQ-025 Changes to bit8, parity_en or odd_n_even mid-frame SHALL take effect only from the next START.

Reset
REQ-026 aresetn=0: FSM to IDLE, counters to 0, synchronizer/filter to 1, data_out=0x00, and rx_rdy, overflow, parity_err, framing_err all 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no completion; after release, the FSM SHALL wait in IDLE for a new start bit.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: parity_en/odd_n_even SHALL be honoured, the PARITY state SHALL be built, and parity_err SHALL be driven.
REQ-029 Macro UART_RX_PARITY_EN undefined: PARITY SHALL be omitted, parity_en/odd_n_even ignored, parity_err tied 0, and ports unchanged.

Verification
REQ-030 8N1, baud_clock every 4 clk, rx sends 0xA5 -> data_out=0xA5, rx_rdy=1, all error flags 0.
REQ-031 rx low for 4 baud_clock pulses, then high -> FSM returns to IDLE, rx_rdy stays 0.
REQ-032 With macro, 8E1, 0x37 sent with parity bit 0 -> data_out=0x37, parity_err=1.
REQ-033 0x55 sent with stop bit 0 -> framing_err=1, rx_rdy=1; a following good 0x12 after read_ack -> framing_err=0.
REQ-034 0x11 then 0x22, no read_ack -> data_out=0x11, overflow=1; read_ack -> rx_rdy=0, overflow=0.
REQ-035 aresetn pulsed low in DATA of 0x3C -> all outputs 0; a subsequent 0x7E is received correctly.
